// File: rtl/opc_pkg.sv
// Shared widths and enums for the OPC memory arbiter.
package opc_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic {
    REQ_CPU  = 1'b0,
    REQ_HOST = 1'b1
  } req_id_e;

endpackage

// File: rtl/opc_arb_pick.sv
// Host-priority winner select with a saturating burst counter that
// guarantees a pending CPU request gets through.
module opc_arb_pick
  import opc_pkg::*;
#(
  parameter int HOST_BURST = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    cpu_req,
  input  logic    host_req,
  input  logic    grant,
  input  req_id_e grant_id,
  output req_id_e winner
);

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(HOST_BURST);

  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) burst_cnt_q <= '0;
    else     burst_cnt_q <= burst_cnt_d;
  end

  always_comb begin
    winner = REQ_CPU;
    if (host_req && !(cpu_req && (burst_cnt_q == BURST_MAX))) winner = REQ_HOST;
  end

  // Only host grants taken over a waiting CPU count toward the burst limit.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (grant) begin
      if ((grant_id == REQ_HOST) && cpu_req) begin
        if (burst_cnt_q != BURST_MAX) burst_cnt_d = burst_cnt_q + 4'd1;
      end else begin
        burst_cnt_d = '0;
      end
    end
  end

endmodule

// File: rtl/opc_mem_arbiter.sv
// Shares one synchronous single-port SRAM between the OPC CPU and the host
// loader, one req/ack transaction at a time.
//
// state  | meaning
// IDLE   | no access; arbitrate and latch the winner's request
// ACCESS | mem_en strobe for the single SRAM cycle
// WAIT   | count down the read latency, capture read data at the end
// DONE   | pulse the winner's ack
module opc_mem_arbiter
  import opc_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int HOST_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT);

  state_e            state_q, state_d;
  req_id_e           winner_q, winner_d, pick;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              grant;

  opc_arb_pick #(.HOST_BURST(HOST_BURST)) u_pick (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .host_req (host_req),
    .grant    (grant),
    .grant_id (pick),
    .winner   (pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      winner_q     <= REQ_CPU;
      wait_cnt_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    wait_cnt_d   = wait_cnt_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    grant        = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req || host_req) begin
          grant    = 1'b1;
          winner_d = pick;
          state_d  = ACCESS;
          if (pick == REQ_HOST) begin
            mem_we_d    = host_we;
            mem_addr_d  = host_addr;
            mem_wdata_d = host_wdata;
          end else begin
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end
        end
      end
      ACCESS: begin
        wait_cnt_d = WAIT_INIT;
        state_d    = mem_we_q ? DONE : WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == 2'd1) begin
          state_d = DONE;
          if (winner_q == REQ_HOST) host_rdata_d = mem_rdata;
          else                      cpu_rdata_d  = mem_rdata;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en   = (state_q == ACCESS);
    busy     = (state_q != IDLE);
    cpu_ack  = (state_q == DONE) && (winner_q == REQ_CPU);
    host_ack = (state_q == DONE) && (winner_q == REQ_HOST);
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;

endmodule
